// File: rtl/sha256_arbiter.sv
// sha256_arbiter
// Round-robin scheduler sharing one sha256 core between N_REQ message sources.
// A requester owns the core from its first accepted word until its digest has
// been delivered. Only the owner's digest is routed back.
//
// Handshake rule used on every stream here: a beat transfers on a rising clk_i
// edge where valid and ready are both high. A source holds data/last stable
// while valid is high and ready is low. Ready may depend combinationally on
// state and on the downstream ready, never on the same port's valid.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_data_i/last/valid per-requester message words in, req_ready_o back
//   rsp_data_o            digest, broadcast to all requesters
//   rsp_valid_o           one-hot digest valid to the owner, rsp_ready_i back
//   core_data_o/last/valid/ready_i   word stream to the core
//   core_data_i/valid_i/ready_o      digest stream from the core
//   grant_o               index of the current (or most recent) owner
//   busy_o                high while an owner holds the core
//   state_o               FSM state for debug (0 IDLE, 1 FEED, 2 WAIT)
module sha256_arbiter #(
  parameter int N_REQ   = 4,
  parameter int I_WIDTH = 32,
  parameter int O_WIDTH = 256
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [N_REQ-1:0][I_WIDTH-1:0]      req_data_i,
  input  logic [N_REQ-1:0]                   req_last_i,
  input  logic [N_REQ-1:0]                   req_valid_i,
  output logic [N_REQ-1:0]                   req_ready_o,
  output logic [O_WIDTH-1:0]                 rsp_data_o,
  output logic [N_REQ-1:0]                   rsp_valid_o,
  input  logic [N_REQ-1:0]                   rsp_ready_i,
  output logic [I_WIDTH-1:0]                 core_data_o,
  output logic                               core_last_o,
  output logic                               core_valid_o,
  input  logic                               core_ready_i,
  input  logic [O_WIDTH-1:0]                 core_data_i,
  input  logic                               core_valid_i,
  output logic                               core_ready_o,
  output logic [$clog2(N_REQ)-1:0]           grant_o,
  output logic                               busy_o,
  output logic [1:0]                         state_o
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] pick_idx;
  logic          pick_vld;
  logic [GW:0]   scan_idx;
  logic [GW-1:0] rr_next;
  logic          feed_last_xfer;
  logic          rsp_xfer;

  assign state_o = state;

  // Circular search starting at rr_ptr. The extra index bit lets the sum
  // exceed N_REQ-1 before wrapping, which also covers non-power-of-2 N_REQ.
  always_comb begin
    pick_idx = rr_ptr;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + (GW+1)'(i);
      if (scan_idx >= (GW+1)'(N_REQ)) begin
        scan_idx = scan_idx - (GW+1)'(N_REQ);
      end
      if (!pick_vld && req_valid_i[scan_idx[GW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx[GW-1:0];
      end
    end
  end

  // The requester just served drops to lowest priority next time round.
  assign rr_next = (grant_o == GW'(N_REQ-1)) ? '0 : grant_o + GW'(1);

  // Pass-through muxing. Data/last follow grant_o in every state; only the
  // valid/ready qualifiers are gated by state.
  always_comb begin
    core_data_o  = req_data_i[grant_o];
    core_last_o  = req_last_i[grant_o];
    core_valid_o = 1'b0;
    req_ready_o  = '0;
    rsp_data_o   = core_data_i;
    rsp_valid_o  = '0;
    core_ready_o = 1'b0;
    if (state == FEED) begin
      core_valid_o         = req_valid_i[grant_o];
      req_ready_o[grant_o] = core_ready_i;
    end
    if (state == WAIT) begin
      rsp_valid_o[grant_o] = core_valid_i;
      core_ready_o         = rsp_ready_i[grant_o];
    end
  end

  assign feed_last_xfer = core_valid_o && core_ready_i && core_last_o;
  assign rsp_xfer       = core_valid_i && core_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      grant_o <= '0;
      busy_o  <= 1'b0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_o <= pick_idx;
            busy_o  <= 1'b1;
            state   <= FEED;
          end
        end
        FEED: begin
          if (feed_last_xfer) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Grant is only released once the digest has left the core, so a
          // stalled owner blocks everyone else.
          if (rsp_xfer) begin
            rr_ptr <= rr_next;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_arbiter.sv
module tb_sha256_arbiter;

  localparam int N = 4;

  localparam logic [255:0] SHA_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  // ---------------- clock / reset ----------------
  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [N-1:0][31:0]    req_data_i;
  logic [N-1:0]          req_last_i;
  logic [N-1:0]          req_valid_i;
  logic [N-1:0]          req_ready_o;
  logic [255:0]          rsp_data_o;
  logic [N-1:0]          rsp_valid_o;
  logic [N-1:0]          rsp_ready_i;
  logic [31:0]           core_data_o;
  logic                  core_last_o;
  logic                  core_valid_o;
  logic                  core_ready_i;
  logic [255:0]          core_data_i;
  logic                  core_valid_i;
  logic                  core_ready_o;
  logic [1:0]            grant_o;
  logic                  busy_o;
  logic [1:0]            state_o;

  always #5 clk_i = ~clk_i;

  sha256_arbiter #(.N_REQ(N), .I_WIDTH(32), .O_WIDTH(256)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_data_i(req_data_i), .req_last_i(req_last_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .core_data_o(core_data_o), .core_last_o(core_last_o), .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
    .core_data_i(core_data_i), .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
    .grant_o(grant_o), .busy_o(busy_o), .state_o(state_o));

  // ---------------- golden sha256 ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [255:0] sha_blk(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
             + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, hh} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + hh};
  endfunction

  // Blocks of 16 words; a short final block is zero-filled.
  function automatic logic [255:0] digest_of(input logic [31:0] ws [64], input int n);
    logic [255:0] h;
    logic [511:0] blk;
    h = SHA_IV;
    blk = '0;
    for (int i = 0; i < n; i++) begin
      blk[511-32*(i%16) -: 32] = ws[i];
      if ((i % 16) == 15 || i == n - 1) begin
        h = sha_blk(h, blk);
        blk = '0;
      end
    end
    return h;
  endfunction

  // ---------------- sha256 core stand-in ----------------
  logic [511:0] cm_blk;
  int           cm_cnt;
  logic [255:0] cm_h;
  int           cm_lat;
  logic         cm_pend;

  always @(posedge clk_i) begin : core_model
    logic [511:0] nb;
    logic         beat, next_pend;
    if (rst_i) begin
      cm_blk <= '0; cm_cnt <= 0; cm_h <= SHA_IV; cm_lat <= 0; cm_pend <= 1'b0;
      core_valid_i <= 1'b0; core_data_i <= '0; core_ready_i <= 1'b0;
    end else begin
      beat = core_valid_o && core_ready_i;
      next_pend = (cm_pend && !(core_valid_i && core_ready_o)) || (beat && core_last_o);
      if (beat) begin
        nb = cm_blk;
        nb[511-32*cm_cnt -: 32] = core_data_o;
        if (cm_cnt == 15 || core_last_o) begin
          cm_h <= sha_blk(cm_h, nb);
          cm_blk <= '0;
          cm_cnt <= 0;
        end else begin
          cm_blk <= nb;
          cm_cnt <= cm_cnt + 1;
        end
        if (core_last_o) begin
          cm_pend <= 1'b1;
          cm_lat <= 3;
        end
      end else if (cm_lat > 0) begin
        cm_lat <= cm_lat - 1;
      end
      if (core_valid_i && core_ready_o) begin
        core_valid_i <= 1'b0;
        cm_pend <= 1'b0;
        cm_h <= SHA_IV;
      end else if (cm_pend && cm_lat == 0 && !core_valid_i) begin
        core_valid_i <= 1'b1;
        core_data_i <= cm_h;
      end
      core_ready_i <= !next_pend && ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        v;
    logic        last;
    logic [31:0] d;
  } slot_t;

  slot_t        sq [N][$];
  logic [255:0] exp_q [$];
  int           exp_own_q [$];
  int           exp_grant_q [$];
  int           checks = 0;
  int           errors = 0;
  int           own = -1;
  bit           in_wait = 1'b0;
  bit           post_hs = 1'b0;
  int           stall_left = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] spec_word(input int i);
    int k;
    k = i % 16;
    if (k == 0) return (i < 16) ? 32'h20000000 : 32'h20020000;
    if (k == 14) return 32'h00000080;
    if (k == 15) return 32'h0a112001;
    return 32'h0;
  endfunction

  // ---------------- driver ----------------
  task automatic build_msg(input int r, input int n, input int pat, input bit bub,
                           output logic [255:0] dig);
    logic [31:0] ws [64];
    slot_t s;
    for (int i = 0; i < 64; i++) ws[i] = '0;
    for (int i = 0; i < n; i++) ws[i] = (pat == 0) ? spec_word(i) : $urandom;
    for (int i = 0; i < n; i++) begin
      s.v = 1'b1; s.last = (i == n - 1); s.d = ws[i];
      sq[r].push_back(s);
      if (bub && (i % 4) == 3 && i != n - 1) begin
        s.v = 1'b0; s.last = 1'b0; s.d = '0;
        repeat (3) sq[r].push_back(s);
      end
    end
    dig = digest_of(ws, n);
  endtask

  task automatic run_traffic(input int budget, input int abort_beats, output int beats);
    int   cyc;
    bit   done;
    logic [N-1:0] hs, own_bit;
    beats = 0; cyc = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk_i);
      for (int r = 0; r < N; r++) begin
        if (sq[r].size() > 0) begin
          req_valid_i[r] = sq[r][0].v; req_last_i[r] = sq[r][0].last; req_data_i[r] = sq[r][0].d;
        end else begin
          req_valid_i[r] = 1'b0; req_last_i[r] = 1'b0;
        end
      end
      rsp_ready_i = '1;
      if (core_valid_i && stall_left > 0) begin
        rsp_ready_i = '0;
        stall_left--;
      end
      #1;
      if (post_hs) begin
        check("busy_fall", busy_o, 0);
        post_hs = 1'b0;
      end
      if (own < 0 && busy_o) begin
        if (exp_grant_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: grant_o=%0d none required", grant_o);
          own = int'(grant_o);
        end else begin
          own = exp_grant_q.pop_front();
          check("grant", grant_o, own);
        end
      end
      own_bit = (own >= 0) ? (4'b0001 << own) : 4'b0000;
      if (own >= 0 && !in_wait) begin
        check("req_ready", req_ready_o, own_bit & {N{core_ready_i}});
        check("core_valid", core_valid_o, req_valid_i[own]);
        if (core_valid_o) begin
          check("core_data", core_data_o, req_data_i[own]);
          check("core_last", core_last_o, req_last_i[own]);
        end
      end else begin
        check("req_ready_idle", req_ready_o, 0);
        check("core_valid_idle", core_valid_o, 0);
      end
      if (in_wait) begin
        check("core_ready", core_ready_o, rsp_ready_i[own]);
        check("rsp_valid", rsp_valid_o, core_valid_i ? own_bit : 4'b0000);
      end else begin
        check("core_ready_idle", core_ready_o, 0);
        check("rsp_valid_idle", rsp_valid_o, 0);
      end
      if (own >= 0) check("grant_hold", grant_o, own);
      hs = rsp_valid_o & rsp_ready_i;
      if (hs != 0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_digest: rsp_valid_o=%b none required", rsp_valid_o);
        end else begin
          check("digest", rsp_data_o, exp_q.pop_front());
          check("rsp_owner", hs, 4'b0001 << exp_own_q.pop_front());
        end
        own = -1; in_wait = 1'b0; post_hs = 1'b1;
      end
      if (core_valid_o && core_ready_i) begin
        beats++;
        if (core_last_o) in_wait = 1'b1;
      end
      for (int r = 0; r < N; r++) begin
        if (sq[r].size() > 0) begin
          if (!sq[r][0].v) void'(sq[r].pop_front());
          else if (req_ready_o[r]) void'(sq[r].pop_front());
        end
      end
      cyc++;
      if (abort_beats > 0 && beats == abort_beats) return;
      done = (sq[0].size() == 0) && (sq[1].size() == 0) && (sq[2].size() == 0) && (sq[3].size() == 0)
             && (exp_q.size() == 0) && (own < 0) && !post_hs && !busy_o;
      if (!done && cyc > budget) begin
        checks++; errors++;
        $display("FAIL timeout: no completion within %0d cycles", budget);
        for (int r = 0; r < N; r++) sq[r].delete();
        exp_q.delete(); exp_own_q.delete(); exp_grant_q.delete();
        done = 1'b1;
      end
    end
  endtask

  // ---------------- test table ----------------
  typedef struct {
    logic [3:0]      mask;
    int              msgs;
    int              nwords;
    int              pat;
    bit              bubble;
    bit              stall;
    int              exp_beats;
    int              n_grants;
    logic [7:0][3:0] order;   // element 0 is the first expected grant
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [255:0] dig [N][2];
    int           occ [N];
    int           beats, r;
    logic [255:0] d;

    // rr pointer history is part of each row's expected order.
    tbl[0] = '{mask: 4'b0101, msgs: 1, nwords: 16, pat: 1, bubble: 0, stall: 0,
               exp_beats: 32, n_grants: 2, order: {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0}};
    tbl[1] = '{mask: 4'b1000, msgs: 1, nwords: 1, pat: 1, bubble: 0, stall: 0,
               exp_beats: 1, n_grants: 1, order: {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3}};
    tbl[2] = '{mask: 4'b1111, msgs: 2, nwords: 16, pat: 1, bubble: 0, stall: 0,
               exp_beats: 128, n_grants: 8, order: {4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0}};
    tbl[3] = '{mask: 4'b0001, msgs: 1, nwords: 32, pat: 0, bubble: 0, stall: 0,
               exp_beats: 32, n_grants: 1, order: {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    tbl[4] = '{mask: 4'b0010, msgs: 1, nwords: 32, pat: 0, bubble: 1, stall: 1,
               exp_beats: 32, n_grants: 1, order: {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1}};

    rst_i = 1'b1; req_valid_i = '0; req_last_i = '0; req_data_i = '0; rsp_ready_i = '1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_state", state_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_req_ready", req_ready_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_core_valid", core_valid_o, 0);
    check("rst_core_ready", core_ready_o, 0);

    for (int t = 0; t < 5; t++) begin
      for (int q = 0; q < N; q++) occ[q] = 0;
      for (int q = 0; q < N; q++)
        if (tbl[t].mask[q])
          for (int k = 0; k < tbl[t].msgs; k++) build_msg(q, tbl[t].nwords, tbl[t].pat, tbl[t].bubble, dig[q][k]);
      for (int g = 0; g < tbl[t].n_grants; g++) begin
        r = int'(tbl[t].order[g]);
        exp_q.push_back(dig[r][occ[r]]);
        exp_own_q.push_back(r);
        exp_grant_q.push_back(r);
        occ[r]++;
      end
      stall_left = tbl[t].stall ? 10 : 0;
      run_traffic(4000, 0, beats);
      check($sformatf("beats_row%0d", t), beats, tbl[t].exp_beats);
      check($sformatf("grants_left_row%0d", t), exp_grant_q.size(), 0);
    end

    // Reset in the middle of a message from requester 1.
    build_msg(1, 16, 1, 1'b0, d);
    exp_grant_q.push_back(1);
    run_traffic(4000, 8, beats);
    check("abort_beats", beats, 8);
    rst_i = 1'b1;
    req_valid_i = '0;
    sq[1].delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    own = -1; in_wait = 1'b0; post_hs = 1'b0; stall_left = 0;
    check("mid_rst_state", state_o, 0);
    check("mid_rst_grant", grant_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_req_ready", req_ready_o, 0);
    check("mid_rst_rsp_valid", rsp_valid_o, 0);
    check("mid_rst_core_valid", core_valid_o, 0);
    check("mid_rst_core_ready", core_ready_o, 0);

    build_msg(1, 16, 1, 1'b0, d);
    exp_q.push_back(d);
    exp_own_q.push_back(1);
    exp_grant_q.push_back(1);
    run_traffic(4000, 0, beats);
    check("post_rst_beats", beats, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_arbiter.md
Name: sha256_arbiter

Overview:
- Round-robin scheduler that shares one sha256 core between N_REQ independent message sources.
- Each requester streams 32-bit words of pre-padded message blocks. The arbiter locks the core to one requester from its first beat until the digest is returned.
- It routes the digest back to the owning requester only.
- Sits between client stream ports and the sha256 core's in_*/out_* valid/ready interface.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- I_WIDTH, 32, input word width, equal to the core's in_data_i width.
- O_WIDTH, 256, digest width, equal to the core's out_data_o width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_data_i  in  N_REQ*I_WIDTH  per-requester message word, packed [N_REQ-1:0][I_WIDTH-1:0]
- req_last_i  in  N_REQ  final word of message, per requester
- req_valid_i  in  N_REQ  word valid, per requester
- req_ready_o  out  N_REQ  word accepted, per requester
- rsp_data_o  out  O_WIDTH  digest, broadcast to all requesters
- rsp_valid_o  out  N_REQ  digest valid, one-hot to the owner
- rsp_ready_i  in  N_REQ  digest accepted, per requester
- core_data_o  out  I_WIDTH  to core in_data_i
- core_last_o  out  1  to core in_last_i
- core_valid_o  out  1  to core in_valid_i
- core_ready_i  in  1  from core in_ready_o
- core_data_i  in  O_WIDTH  from core out_data_o
- core_valid_i  in  1  from core out_valid_o
- core_ready_o  out  1  to core out_ready_i
- grant_o  out  $clog2(N_REQ)  index of current owner
- busy_o  out  1  high in FEED or WAIT

Behaviour:
- Reset and clock: one clock domain (clk_i). Reset is synchronous, active-high (rst_i). The core's active-low rst_n_i is driven from ~rst_i at top level, so the core and arbiter reset together.
- Reset values:
  - state = IDLE
  - grant_o = 0, busy_o = 0
  - req_ready_o = 0, rsp_valid_o = 0
  - core_valid_o = 0, core_ready_o = 0
  - rr pointer = 0, so requester 0 has top priority on the first arbitration
- State machine: IDLE -> FEED -> WAIT -> IDLE.
- IDLE:
  - If any req_valid_i is set, pick the first set bit searching circularly from the rr pointer.
  - Register it into grant_o and go to FEED next cycle (1-cycle arbitration latency).
  - No ready is asserted in IDLE.
- FEED (combinational pass-through of the granted requester g):
  - core_data_o = req_data_i[g], core_last_o = req_last_i[g]
  - core_valid_o = req_valid_i[g]
  - req_ready_o[g] = core_ready_i; all other req_ready_o bits are 0.
  - A beat transfers when core_valid_o && core_ready_i.
  - A transferred beat with core_last_o = 1 moves to WAIT next cycle.
  - A single-beat message (last on first beat) is legal.
- WAIT:
  - rsp_data_o = core_data_i; rsp_valid_o[g] = core_valid_i; core_ready_o = rsp_ready_i[g].
  - Non-owner rsp_valid_o bits stay 0.
  - The digest transfers when core_valid_i && rsp_ready_i[g]. The next cycle enters IDLE and sets rr pointer = (g+1) mod N_REQ.
- Outside FEED: core_valid_o = 0. core_data_o/core_last_o keep muxing grant_o but are don't-care.
- Outside WAIT: core_ready_o = 0. A stray core_valid_i is held by the core, not dropped.
- busy_o = (state != IDLE). grant_o holds its value through IDLE until the next grant.
- Boundary conditions:
  - The owner may drop req_valid_i mid-message (bubbles). The grant is held indefinitely and core_valid_o follows the bubble.
  - Non-owner req_valid_i is ignored and its data is not consumed; the requester must hold it.
  - rsp_ready_i low stalls WAIT indefinitely. No new grant is made while a digest is undelivered.
  - A requester asserting valid in the same cycle its digest is delivered is eligible at the next IDLE arbitration, with lowest priority relative to others.
  - rst_i mid-FEED or mid-WAIT: next cycle is IDLE with reset values. Partial messages are abandoned and the pending digest is discarded; the core resets simultaneously.
  - N_REQ not a power of 2: the pointer wraps at N_REQ-1 -> 0.

Test Plan:
- Requester 0 sends a 32-word, two-block message: block 0 = 0x20000000, 13x0, 0x00000080, 0x0a112001 (padded to 16); block 1 identical except word0 = 0x20020000; last on word 31. Required: exactly 32 core beats; rsp_valid_o = 4'b0001; rsp_data_o equals the golden-model digest; busy_o falls the cycle after the digest handshake.
- Requesters 0 and 2 raise valid in the same cycle, each with a 16-word message. Required: grant_o = 0 first, then 2. Requester 2 sees no req_ready_o until requester 0's digest transfers. Digests go to rsp_valid_o 4'b0001, then 4'b0100.
- All 4 requesters hold valid continuously for 8 messages. Required: grant order 0,1,2,3,0,1,2,3 and each digest only on its owner's rsp_valid_o bit.
- Owner inserts 3-cycle valid bubbles every 4 words, and rsp_ready_i is held low 10 cycles after core_valid_i. Required: the digest matches the no-bubble run, core_valid_o mirrors the bubbles, and no grant change occurs during the stall.
- Single-word message (last on beat 0) from requester 3. Required: FEED lasts 1 transfer, then WAIT; the digest is returned to requester 3.
- Assert rst_i for 1 cycle after word 7 of a message from requester 1. Required: next cycle state = IDLE, all ready/valid outputs 0, grant_o = 0. A fresh message from requester 1 afterwards yields the correct golden-model digest.
